// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit hex seven-segment driver: frame-coherent number latch, leading-zero
// blanking, PWM brightness and output polarity. Define SEVEN_SEGMENT_SCAN_BLINK_EN for per-digit blink.
module seven_segment_scan #(
  parameter int N_DIGITS         = 8,
  parameter int BRIGHT_W         = 3,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES   = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*N_DIGITS-1:0]   num,
  input  logic [N_DIGITS-1:0]     dots,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]     blink,
`endif
  output logic [6:0]              abcdefg,
  output logic                    dot,
  output logic [N_DIGITS-1:0]     anodes
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  logic [IDX_W-1:0]        idx;
  logic [4*N_DIGITS-1:0]   num_l;
  logic [N_DIGITS-1:0]     dots_l;
  logic [N_DIGITS-1:0]     lz_l;
  logic [N_DIGITS-1:0]     lz_next;
  logic [N_DIGITS-1:0]     blink_mask;
  logic [BRIGHT_W-1:0]     pwm;
  logic                    wrap;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_d, seg_q;
  logic                    dot_d, dot_q;
  logic [N_DIGITS-1:0]     an_d, an_q;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    s = '0;
    case (nib)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      4'hF: s = 7'b1000111;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign wrap = en && (idx == LAST_IDX);

  // Digit i blanks when every nibble from i upward is zero; scan down from the top.
  always_comb begin
    logic zero_above;
    // NOTE: blocking assignments in combinational logic so zero_above accumulates in loop order.
    zero_above = 1'b1;
    lz_next    = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (num[4*i +: 4] == 4'h0);
      lz_next[i] = blank_lz && zero_above;
    end
  end

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (en) begin
      idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

  // NOTE: every register here is reset; there is no memory array, so nothing is left uninitialised.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_l  <= '0;
      dots_l <= '0;
      lz_l   <= '0;
    end else if (wrap) begin
      num_l  <= num;
      dots_l <= dots;
      lz_l   <= lz_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm <= '0;
    else        pwm <= pwm + BRIGHT_W'(1);
  end

`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;
  logic [N_DIGITS-1:0] blink_l;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      blink_l     <= '0;
    end else if (wrap) begin
      blink_l <= blink;
      if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end

  assign blink_mask = blink_phase ? blink_l : '0;
`else
  assign blink_mask = '0;
`endif

  // All-ones brightness is continuously on rather than lit for 2^W-1 of 2^W clocks.
  assign lit     = (brightness == '1) || (pwm < brightness);
  assign cur_nib = num_l[{idx, 2'b00} +: 4];

  always_comb begin
    seg_d = '0;
    dot_d = 1'b0;
    an_d  = '0;
    if (lit) begin
      an_d[idx] = 1'b1;
      if (!blink_mask[idx]) begin
        dot_d = dots_l[idx];
        if (!lz_l[idx]) seg_d = decode(cur_nib);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= '0;
      dot_q <= 1'b0;
      an_q  <= '0;
    end else begin
      seg_q <= seg_d;
      dot_q <= dot_d;
      an_q  <= an_d;
    end
  end

  // Registers hold active-high values; polarity is applied only at the pins.
  assign abcdefg = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign dot     = dot_q ^ SEG_ACTIVE_LOW;
  assign anodes  = an_q ^ {N_DIGITS{DIGIT_ACTIVE_LOW}};

endmodule

// File: tb/tb_seven_segment_scan.sv
// Scoreboard bench for seven_segment_scan: a frame-level reference model predicts the pins
// for every clock; a monitor pops and compares one prediction after each rising edge.
module tb_seven_segment_scan;

  localparam int N  = 8;
  localparam int BW = 3;

  typedef struct packed {
    logic [6:0] seg;
    logic       dot;
    logic [7:0] an;
  } out_t;

  localparam out_t DARK = '{seg: 7'h7F, dot: 1'b1, an: 8'hFF};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [31:0] num = '0;
  logic [7:0]  dots = '0;
  logic        blank_lz = 1'b0;
  logic [2:0]  brightness = '0;
  logic [6:0]  abcdefg;
  logic        dot;
  logic [7:0]  anodes;
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
  logic [7:0]  blink = '0;
`endif

  seven_segment_scan #(.N_DIGITS(N), .BRIGHT_W(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .num        (num),
    .dots       (dots),
    .blank_lz   (blank_lz),
    .brightness (brightness),
`ifdef SEVEN_SEGMENT_SCAN_BLINK_EN
    .blink      (blink),
`endif
    .abcdefg    (abcdefg),
    .dot        (dot),
    .anodes     (anodes)
  );

  always #5 clk = ~clk;

  // Active-high segment patterns for hex digits 0..F.
  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  int   vectors = 0;
  int   miscompares = 0;
  out_t exp_q [$];

  // Reference model: which digit is on screen, PWM phase, and the number shown this frame.
  int          m_digit;
  int          m_pwm;
  logic [31:0] m_num;
  logic [7:0]  m_dots;
  bit          m_blz;

  task automatic check(input string name, input out_t act, input out_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got seg=%b dot=%b an=%b, expected seg=%b dot=%b an=%b",
               name, $time, act.seg, act.dot, act.an, exp.seg, exp.dot, exp.an);
    end
  endtask

  function automatic out_t pins();
    out_t o;
    o.seg = abcdefg;
    o.dot = dot;
    o.an  = anodes;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t        o;
    logic [31:0] upper;
    logic [6:0]  pat;
    o = DARK;
    if (brightness == 3'd7 || m_pwm < int'(brightness)) begin
      upper = m_num >> (4 * m_digit);
      pat   = seg_tab[upper[3:0]];
      if (m_blz && m_digit > 0 && upper == 32'd0) pat = 7'd0;
      o.seg = ~pat;
      o.dot = ~m_dots[m_digit];
      o.an  = ~(8'b1 << m_digit);
    end
    return o;
  endfunction

  task automatic model_reset();
    m_digit = 0;
    m_pwm   = 0;
    m_num   = '0;
    m_dots  = '0;
    m_blz   = 1'b0;
  endtask

  task automatic model_step(input logic e);
    m_pwm = (m_pwm + 1) % 8;
    if (e) begin
      if (m_digit == N - 1) begin
        m_digit = 0;
        m_num   = num;
        m_dots  = dots;
        m_blz   = blank_lz;
      end else begin
        m_digit++;
      end
    end
  endtask

  // Called at a falling edge with inputs already set; predicts the next rising edge.
  task automatic cycle(input logic e);
    en = e;
    exp_q.push_back(model_out());
    model_step(e);
    @(negedge clk);
  endtask

  task automatic strobes(input int count, input int period);
    for (int s = 0; s < count; s++) begin
      cycle(1'b1);
      for (int k = 1; k < period; k++) cycle(1'b0);
    end
  endtask

  task automatic mid_reset();
    exp_q.delete();
    #2 reset = 1'b0;
    #1 check("async_reset", pins(), DARK);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin : monitor
    out_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scan", pins(), e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    model_reset();
    #3 reset = 1'b0;
    #1 check("reset_state", pins(), DARK);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Scan order on a fixed number at full brightness.
    brightness = 3'd7;
    num = 32'h7654_3210;
    strobes(24, 4);

    // Frame coherence: change the number while digit 3 is on screen.
    num = 32'h1111_1111;
    strobes(8, 3);
    while (m_digit != 3) strobes(1, 3);
    num = 32'h2222_2222;
    dots = 8'h5A;
    strobes(12, 3);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    num = 32'h0000_0A05;
    dots = 8'hF0;
    strobes(16, 2);
    num = 32'h0000_0000;
    strobes(16, 2);
    num = 32'h0010_0000;
    strobes(16, 2);

    // Brightness levels, including the dark and always-on ends.
    foreach (seg_tab[b]) begin
      if (b < 8) begin
        brightness = 3'(b);
        strobes(10, 5);
      end
    end
    brightness = 3'd3;
    strobes(10, 8);

    // Asynchronous reset mid-frame, then restart.
    brightness = 3'd7;
    num = 32'h89AB_CDEF;
    dots = 8'hA5;
    strobes(5, 3);
    mid_reset();
    strobes(12, 3);

    // en held high for several frames.
    repeat (40) cycle(1'b1);

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) num = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) dots = 8'($urandom);
      if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(0, 63) == 0) brightness = 3'($urandom);
      cycle($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
